// File: rtl/mips_pkg.sv
// Shared word-size constants and the buffer entry layout used by the
// instruction prefetch path.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } entry_t;

  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
    return {pc[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instr}, synchronous flush,
// head masked to {0, NOP} whenever the buffer is empty.
module prefetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [2*WORD_W-1:0]      push_data,
  input  logic                     pop,
  output logic [2*WORD_W-1:0]      head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [2*WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic                do_push;
  logic                do_pop;

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push && !flush;
  assign do_pop  = pop && (level != '0) && !flush;

  // NOTE: the storage array is deliberately not reset; level alone says
  // which slots are meaningful, and head is masked while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = (level != '0) ? mem[rd_ptr] : {{WORD_W{1'b0}}, NOP};

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: issues sequential fetches into a 1-cycle memory,
// reserving a buffer slot per outstanding fetch, with redirect flush.
module instr_prefetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [31:0]            mem_sel,
  input  logic [31:0]            mem_data,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            instr_out,
  output logic [31:0]            instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0]   fetch_pc;
  logic [WORD_W-1:0]   inflight_pc;
  logic                inflight;
  logic                issue;
  logic [LVL_W:0]      pending;
  logic [2*WORD_W-1:0] head;

  // A fetch in flight already owns a slot, so it counts against capacity.
  assign pending = {1'b0, level} + {{LVL_W{1'b0}}, inflight};
  assign issue   = !redirect && (pending < (LVL_W+1)'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= align_pc(redirect_pc);
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + PC_STEP;
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (inflight),
    .push_data ({inflight_pc, mem_data}),
    .pop       (instr_valid && instr_ready),
    .head      (head),
    .level     (level)
  );

  assign mem_sel               = fetch_pc;
  assign {instr_pc, instr_out} = head;
  assign instr_valid           = (level != '0);

endmodule
